// File: rtl/alu4_issue_if.sv
// Command and result handshake bundle between a producer/consumer and the ALU issue controller.
interface alu4_issue_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_use_acc;
   logic       in_wb;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic [3:0] out_flags;

   modport master (
      output in_valid, in_op, in_a, in_b, in_use_acc, in_wb, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_use_acc, in_wb, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/alu4_issue_ctrl.sv
// Issue/writeback controller around a 4-bit signed ALU: registers operands, captures
// result and NZCV, optionally writes back to an accumulator, keeps a sticky overflow.
//
// state | meaning
// IDLE  | no command in flight, ready to accept
// EXEC  | operands registered, ALU settling, capture at next edge
// HOLD  | result presented downstream, waiting for out_ready
module alu4_issue_ctrl #(
   parameter logic [3:0] ACC_INIT = 4'b0000
) (
   input  logic         clk,
   input  logic         rst,
   alu4_issue_if.slave  bus,
   output logic [3:0]   alu_a,
   output logic [3:0]   alu_b,
   output logic [2:0]   alu_ctrl,
   input  logic [3:0]   alu_result,
   input  logic         alu_n,
   input  logic         alu_z,
   input  logic         alu_c,
   input  logic         alu_v,
   output logic [3:0]   acc,
   output logic         ovf_sticky,
   input  logic         clr_sticky
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       accept;
   logic       ready;
   logic       valid;
   logic       wb_r;
   logic [3:0] result_r;
   logic [3:0] flags_r;
   logic       arith_op;

   // The ALU only defines C and V for add (000) and sub (001).
   assign arith_op = (alu_ctrl[2:1] == 2'b00);

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid     = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            valid = 1'b1;
            ready = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  accept    = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= ACC_INIT;
         alu_a      <= 4'b0000;
         alu_b      <= 4'b0000;
         alu_ctrl   <= 3'b000;
         wb_r       <= 1'b0;
         result_r   <= 4'b0000;
         flags_r    <= 4'b0000;
         ovf_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_a    <= bus.in_use_acc ? acc : bus.in_a;
            alu_b    <= bus.in_b;
            alu_ctrl <= bus.in_op;
            wb_r     <= bus.in_wb;
         end
         if (state == EXEC) begin
            result_r <= alu_result;
            flags_r  <= {alu_n, alu_z, alu_c & arith_op, alu_v & arith_op};
            if (wb_r) begin
               acc <= alu_result;
            end
         end
         // Setting has priority over a simultaneous clear.
         if ((state == EXEC) && arith_op && alu_v) begin
            ovf_sticky <= 1'b1;
         end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out_valid  = valid;
   assign bus.out_result = result_r;
   assign bus.out_flags  = flags_r;

endmodule
